// File: rtl/serial7_pkg.sv
// Shared constants and state encoding for the serial7 receiver.
package serial7_pkg;

  localparam int unsigned WORD_W = 7;

  localparam logic [WORD_W-1:0] SYNC_WORD_DFLT = 7'b1110101;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCK    = 2'd2
  } state_e;

endpackage

// File: rtl/serial7_deser.sv
// Serial window shift register and word-boundary bit counter.
module serial7_deser
  import serial7_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              realign,
  output logic [WORD_W-1:0] next_win,
  output logic              boundary
);

  logic [WORD_W-1:0] win_q;
  logic [2:0]        bcnt_q, bcnt_d;

  assign next_win = {win_q[WORD_W-2:0], din};
  assign boundary = (bcnt_q == 3'(WORD_W - 1));

  // realign makes the edge after a hunt match count as bit 0 of the next word
  always_comb begin
    bcnt_d = bcnt_q + 3'd1;
    if (realign || boundary) begin
      bcnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_q  <= '0;
      bcnt_q <= '0;
    end else begin
      win_q  <= next_win;
      bcnt_q <= bcnt_d;
    end
  end

endmodule

// File: rtl/serial7_rx.sv
// Serial-to-parallel receiver: sync-word hunt, lock confirmation, word output
// and lock loss after too many consecutive non-sync words.
module serial7_rx
  import serial7_pkg::state_e;
  import serial7_pkg::HUNT;
  import serial7_pkg::LOCK;
  import serial7_pkg::WORD_W;
  import serial7_pkg::SYNC_WORD_DFLT;
#(
  parameter logic [6:0]  SYNC_WORD = SYNC_WORD_DFLT,
  parameter int unsigned CONFIRM   = 2,
  parameter int unsigned MAX_GAP   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  output logic [WORD_W-1:0] dout,
  output logic              dout_valid,
  output logic              locked,
  output logic              sync_err
);

  state_e            state_q, state_d;
  logic [2:0]        mcnt_q, mcnt_d;
  logic [3:0]        gcnt_q, gcnt_d;
  logic [WORD_W-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              locked_q, locked_d;
  logic              err_q, err_d;

  logic [WORD_W-1:0] next_win;
  logic              boundary;
  logic              realign;
  logic              is_sync;

  serial7_deser u_deser (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .realign  (realign),
    .next_win (next_win),
    .boundary (boundary)
  );

  assign is_sync = (next_win == SYNC_WORD);

  always_comb begin
    state_d = state_q;
    mcnt_d  = mcnt_q;
    gcnt_d  = gcnt_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    realign = 1'b0;
    unique case (state_q)
      HUNT: begin
        if (is_sync) begin
          realign = 1'b1;
          mcnt_d  = 3'd1;
          gcnt_d  = '0;
          state_d = (CONFIRM == 1) ? LOCK : serial7_pkg::CONFIRM;
        end
      end
      serial7_pkg::CONFIRM: begin
        if (boundary) begin
          if (is_sync) begin
            mcnt_d = mcnt_q + 3'd1;
            if (mcnt_d == 3'(CONFIRM)) begin
              state_d = LOCK;
              gcnt_d  = '0;
            end
          end else begin
            state_d = HUNT;
            mcnt_d  = '0;
          end
        end
      end
      LOCK: begin
        if (boundary) begin
          if (is_sync) begin
            gcnt_d = '0;
          end else begin
            // the word that exhausts the gap budget is still delivered
            dout_d  = next_win;
            valid_d = 1'b1;
            gcnt_d  = gcnt_q + 4'd1;
            if (gcnt_d == 4'(MAX_GAP)) begin
              state_d = HUNT;
              err_d   = 1'b1;
              gcnt_d  = '0;
              mcnt_d  = '0;
            end
          end
        end
      end
      default: begin
        state_d = HUNT;
        mcnt_d  = '0;
        gcnt_d  = '0;
      end
    endcase
    locked_d = (state_d == LOCK);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= HUNT;
      mcnt_q   <= '0;
      gcnt_q   <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcnt_q   <= mcnt_d;
      gcnt_q   <= gcnt_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign locked     = locked_q;
  assign sync_err   = err_q;

endmodule
